alu_bist_ctrl: RTL and testbench

- Self-test sequencer that wraps the 4-bit ALU under test, either the golden ALU or any mutant.
- Upstream role: drives every {opcode, A, B} combination into the ALU.
- Downstream role: samples the ALU's result and zero flag, compares them against an internal golden model, counts mismatches and latches the first failing vector.
- Used by mutation-testing benches and on-chip BIST to grade each mutant in one run.

---
 rtl/alu_bist_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_bist_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_bist_ctrl.sv
// ---------------------------------------------------------------------------
// alu_bist_ctrl
//
// Self-test sequencer for a 4-bit ALU. It sweeps every {opcode, A, B}
// combination into the ALU, holds each vector for SETTLE cycles, and then
// compares the ALU result and zero flag against an internal golden model.
// It counts mismatches and latches the first failing vector.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle sweep request (ignored while busy)
//   alu_a/alu_b/alu_op operands and opcode driven to the ALU
//   dut_result/zero    ALU response, combinational from the operand buses
//   busy, done, pass   sweep status
//   fail_count         mismatching vectors in the current or last sweep
//   first_fail_*       {op,a,b} and result of the first mismatch
// ---------------------------------------------------------------------------
module alu_bist_ctrl #(
    parameter int unsigned SETTLE       = 1,    // 1..15 cycles per vector
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [3:0]  dut_result,
    input  logic        dut_zero,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [11:0] fail_count,
    output logic        first_fail_valid,
    output logic [10:0] first_fail_vec,
    output logic [3:0]  first_fail_result
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [10:0] IDX_LAST    = 11'h7FF;

    logic [1:0]  state;
    logic [10:0] idx;       // {op, a, b}; b increments fastest
    logic [3:0]  wait_cnt;

    logic [3:0]  golden_res;
    logic        golden_zero;
    logic        mismatch;

    // Operand buses are the fields of the registered vector index, so they
    // change only on clock edges and freeze when the sweep stops.
    assign alu_op = idx[10:8];
    assign alu_a  = idx[7:4];
    assign alu_b  = idx[3:0];

    assign busy = (state == ST_DRIVE) || (state == ST_SAMPLE);
    assign done = (state == ST_DONE);
    assign pass = done && (fail_count == 12'd0);

    // Golden model: 4-bit wrap-around arithmetic, unsigned compares.
    // NOTE: golden_res gets a default before the case so no path leaves it
    // unassigned; an always_comb without full assignment infers a latch.
    always_comb begin
        golden_res = 4'd0;
        case (alu_op)
            3'd0:    golden_res = alu_a + alu_b;
            3'd1:    golden_res = alu_a - alu_b;
            3'd2:    golden_res = alu_a & alu_b;
            3'd3:    golden_res = alu_a | alu_b;
            3'd4:    golden_res = alu_a ^ alu_b;
            3'd5:    golden_res = (alu_a == alu_b) ? 4'd1 : 4'd0;
            3'd6:    golden_res = (alu_a <  alu_b) ? 4'd1 : 4'd0;
            default: golden_res = 4'd0;
        endcase
    end

    assign golden_zero = (golden_res == 4'd0);
    assign mismatch    = (dut_result != golden_res) || (dut_zero != golden_zero);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of code order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            idx               <= '0;
            wait_cnt          <= '0;
            fail_count        <= '0;
            first_fail_valid  <= 1'b0;
            first_fail_vec    <= '0;
            first_fail_result <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        fail_count        <= '0;
                        first_fail_valid  <= 1'b0;
                        first_fail_vec    <= '0;
                        first_fail_result <= '0;
                        idx               <= '0;
                        wait_cnt          <= '0;
                        state             <= ST_DRIVE;
                    end
                end

                ST_DRIVE: begin
                    if (wait_cnt == SETTLE_LAST) begin
                        wait_cnt <= '0;
                        state    <= ST_SAMPLE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                ST_SAMPLE: begin
                    if (mismatch) begin
                        // At most 2048 mismatches per sweep, so 12 bits never wrap.
                        fail_count <= fail_count + 12'd1;
                        if (!first_fail_valid) begin
                            first_fail_valid  <= 1'b1;
                            first_fail_vec    <= idx;
                            first_fail_result <= dut_result;
                        end
                    end
                    if ((idx == IDX_LAST) || (STOP_ON_FAIL && mismatch)) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 11'd1;
                        state <= ST_DRIVE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_bist_ctrl
//
// Two sequencers share clk/rst_n/start: dut0 sweeps everything, dut1 stops
// at the first mismatch. Each drives its own behavioural ALU whose fault
// mode (good, A-bus swizzle, zero flag stuck at 0) is selected per row.
// ---------------------------------------------------------------------------
module tb_alu_bist_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   mode = 0;     // 0 good ALU, 1 A rewired {A0,A3,A1,A2}, 2 zero tied 0

    always #5 clk = ~clk;

    logic [3:0]  alu_a0, alu_b0, alu_a1, alu_b1;
    logic [2:0]  alu_op0, alu_op1;
    logic [3:0]  res0, res1;
    logic        zero0, zero1;
    logic        busy0, done0, pass0, ffv0;
    logic        busy1, done1, pass1, ffv1;
    logic [11:0] fc0, fc1;
    logic [10:0] ffvec0, ffvec1;
    logic [3:0]  ffres0, ffres1;

    function automatic logic [4:0] alu_model(input int m, input logic [2:0] op,
                                             input logic [3:0] a_in, input logic [3:0] b);
        logic [3:0] a;
        logic [3:0] r;
        logic       z;
        a = (m == 1) ? {a_in[0], a_in[3], a_in[1], a_in[2]} : a_in;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = (a == b) ? 4'd1 : 4'd0;
            3'd6:    r = (a < b)  ? 4'd1 : 4'd0;
            default: r = 4'd0;
        endcase
        z = (r == 4'd0) && (m != 2);
        return {z, r};
    endfunction

    always_comb begin
        {zero0, res0} = alu_model(mode, alu_op0, alu_a0, alu_b0);
        {zero1, res1} = alu_model(mode, alu_op1, alu_a1, alu_b1);
    end

    alu_bist_ctrl #(.SETTLE(1), .STOP_ON_FAIL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0),
        .dut_result(res0), .dut_zero(zero0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_count(fc0),
        .first_fail_valid(ffv0), .first_fail_vec(ffvec0), .first_fail_result(ffres0)
    );

    alu_bist_ctrl #(.SETTLE(1), .STOP_ON_FAIL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
        .dut_result(res1), .dut_zero(zero1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1),
        .first_fail_valid(ffv1), .first_fail_vec(ffvec1), .first_fail_result(ffres1)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          mode;
        logic [11:0] fc0;      // full-sweep mismatch count
        logic        ffv;
        logic [10:0] vec;      // first failing {op,a,b}
        logic [3:0]  res;      // dut_result at first failure
        int          cyc1;     // cycles until the stop-on-fail unit finishes
        logic [11:0] fc1;
        logic [10:0] last1;    // operands frozen on the stop-on-fail unit
        bit          mid_start;
    } row_t;

    row_t rows[4];

    task automatic check_reset_state(input string tag);
        check({tag, " busy0"},  32'(busy0),  0);
        check({tag, " done0"},  32'(done0),  0);
        check({tag, " pass0"},  32'(pass0),  0);
        check({tag, " fc0"},    32'(fc0),    0);
        check({tag, " ffv0"},   32'(ffv0),   0);
        check({tag, " ffvec0"}, 32'(ffvec0), 0);
        check({tag, " ffres0"}, 32'(ffres0), 0);
        check({tag, " ops0"},   32'({alu_op0, alu_a0, alu_b0}), 0);
        check({tag, " busy1"},  32'(busy1),  0);
        check({tag, " ops1"},   32'({alu_op1, alu_a1, alu_b1}), 0);
    endtask

    task automatic run_row(input int r);
        int  cyc;
        int  cyc1;
        bit  seen1;
        string t;
        t = $sformatf("row%0d", r);
        mode = rows[r].mode;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        // Half a cycle after the accepting edge: results cleared, done dropped.
        check({t, " busy after start"}, 32'(busy0), 1);
        check({t, " done after start"}, 32'(done0), 0);
        check({t, " fc cleared"},       32'(fc0),   0);
        check({t, " ffv cleared"},      32'(ffv0),  0);
        cyc   = 0;
        cyc1  = 0;
        seen1 = 1'b0;
        while (!done0 && cyc < 10000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (!seen1 && done1) begin
                seen1 = 1'b1;
                cyc1  = cyc;
            end
            if (rows[r].mid_start && cyc == 100) start = 1'b1;
            if (rows[r].mid_start && cyc == 101) start = 1'b0;
        end
        check({t, " dut0 done in time"}, 32'(done0), 1);
        check({t, " sweep cycles"},      32'(cyc),   4096);
        check({t, " busy0 at end"},      32'(busy0), 0);
        check({t, " fail_count0"},       32'(fc0),   32'(rows[r].fc0));
        check({t, " pass0"},             32'(pass0), 32'(rows[r].fc0 == 0));
        check({t, " ffv0"},              32'(ffv0),  32'(rows[r].ffv));
        check({t, " ffvec0"},            32'(ffvec0), 32'(rows[r].vec));
        check({t, " ffres0"},            32'(ffres0), 32'(rows[r].res));
        check({t, " ops0 at end"},       32'({alu_op0, alu_a0, alu_b0}), 32'h7FF);
        check({t, " stop cycles"},       32'(cyc1),  32'(rows[r].cyc1));
        check({t, " fail_count1"},       32'(fc1),   32'(rows[r].fc1));
        check({t, " ffvec1"},            32'(ffvec1), 32'(rows[r].vec));
        check({t, " ops1 frozen"},       32'({alu_op1, alu_a1, alu_b1}), 32'(rows[r].last1));
        check({t, " done1"},             32'(done1), 1);
    endtask

    initial begin
        int mut_cnt;
        mut_cnt = 0;
        for (int i = 0; i < 2048; i++) begin
            logic [10:0] v;
            v = 11'(i);
            if (alu_model(1, v[10:8], v[7:4], v[3:0]) != alu_model(0, v[10:8], v[7:4], v[3:0]))
                mut_cnt++;
        end

        //            mode fc0              ffv  vec     res   cyc1  fc1    last1    mid
        rows[0] = '{0, 12'd0,            1'b0, 11'h000, 4'h0, 4096, 12'd0, 11'h7FF, 1'b1};
        rows[1] = '{1, 12'(mut_cnt),     1'b1, 11'h010, 4'h8, 34,   12'd1, 11'h010, 1'b0};
        rows[2] = '{2, 12'd762,          1'b1, 11'h000, 4'h0, 2,    12'd1, 11'h000, 1'b0};
        rows[3] = rows[1];   // restart from DONE must reproduce the same grade

        #12;
        check_reset_state("reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("idle done", 32'(done0), 0);

        for (int r = 0; r < 4; r++) run_row(r);

        // Abort a mutant sweep around idx 500, asynchronously between edges.
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (1000) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_state("abort");
        @(negedge clk) rst_n = 1'b1;
        run_row(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
